// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory request controller: alignment check, one SRAM-like
// transaction per access (address phase then data phase), and load result hand-off.
module mem_access_ctrl #(
  parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_m,
  input  logic [5:0]  op_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        flush,
  input  logic        mem_hold,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic        stall_m,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic [5:0]  op_out,
  output logic [1:0]  addr_low,
  output logic        adel,
  output logic        ades
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   cancel_r;
  logic   is_load_s;
  logic   is_store_s;
  logic   misaligned_s;
  logic   start_s;

  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: size_of = 2'd0;
      OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
      default:              size_of = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] wstrb_of(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   wstrb_of = 4'b0001 << a;
      OP_SH:   wstrb_of = a[1] ? 4'b1100 : 4'b0011;
      OP_SW:   wstrb_of = 4'b1111;
      default: wstrb_of = 4'b0000;
    endcase
  endfunction

  // Stores replicate the source across every lane so the strobes pick the right one.
  function automatic logic [31:0] wdata_of(input logic [5:0] op, input logic [31:0] rt);
    case (op)
      OP_SB:   wdata_of = {4{rt[7:0]}};
      OP_SH:   wdata_of = {2{rt[15:0]}};
      OP_SW:   wdata_of = rt;
      default: wdata_of = 32'h0000_0000;
    endcase
  endfunction

  // Opcode decode and alignment check for the incoming MEM-stage access.
  always_comb begin
    is_load_s    = 1'b0;
    is_store_s   = 1'b0;
    misaligned_s = 1'b0;
    case (op_m)
      OP_LB, OP_LBU: is_load_s = 1'b1;
      OP_LH, OP_LHU: begin is_load_s = 1'b1;  misaligned_s = addr_m[0];      end
      OP_LW:         begin is_load_s = 1'b1;  misaligned_s = |addr_m[1:0];   end
      OP_SB:         is_store_s = 1'b1;
      OP_SH:         begin is_store_s = 1'b1; misaligned_s = addr_m[0];      end
      OP_SW:         begin is_store_s = 1'b1; misaligned_s = |addr_m[1:0];   end
      default:       begin is_load_s = 1'b0;  is_store_s = 1'b0; misaligned_s = 1'b0; end
    endcase
    start_s = (state_r == ST_IDLE) & valid_m & (is_load_s | is_store_s) &
              ~misaligned_s & ~flush & ~mem_hold;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; a cancelled transaction still drains the bus before idling.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: if (start_s) next_state_s = ST_ADDR; else next_state_s = ST_IDLE;
      ST_ADDR: if (data_addr_ok) next_state_s = ST_DATA; else next_state_s = ST_ADDR;
      ST_DATA: begin
        if (data_data_ok) begin
          if (cancel_r) next_state_s = ST_IDLE; else next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_DONE: if (!mem_hold || flush) next_state_s = ST_IDLE; else next_state_s = ST_DONE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM combinational outputs: pipeline stall and address-error flags.
  always_comb begin
    stall_m = start_s | (state_r == ST_ADDR) | (state_r == ST_DATA);
    adel    = (state_r == ST_IDLE) & valid_m & is_load_s & misaligned_s;
    ades    = (state_r == ST_IDLE) & valid_m & is_store_s & misaligned_s;
  end

  // Cancel flag: a flush while the bus is busy marks the transaction as discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cancel_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ADDR: if (flush) cancel_r <= 1'b1;
        ST_DATA: begin
          if (data_data_ok) cancel_r <= 1'b0;
          else if (flush)   cancel_r <= 1'b1;
        end
        default: cancel_r <= 1'b0;
      endcase
    end
  end

  // Request fields: captured on start and held stable through the address phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'h0000_0000;
      data_wstrb <= 4'b0000;
      data_wdata <= 32'h0000_0000;
      op_out     <= 6'b000000;
      addr_low   <= 2'b00;
    end else if (start_s) begin
      data_req   <= 1'b1;
      data_wr    <= is_store_s;
      data_size  <= size_of(op_m);
      data_addr  <= addr_m & ADDR_MASK;
      data_wstrb <= wstrb_of(op_m, addr_m[1:0]);
      data_wdata <= wdata_of(op_m, wdata_m);
      op_out     <= op_m;
      addr_low   <= addr_m[1:0];
    end else if ((state_r == ST_ADDR) && data_addr_ok) begin
      data_req   <= 1'b0;
    end
  end

  // Response capture: stores complete like loads but leave rdata_out untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_out   <= 32'h0000_0000;
      rdata_valid <= 1'b0;
    end else if ((state_r == ST_DATA) && data_data_ok && !cancel_r) begin
      rdata_valid <= 1'b1;
      if (!data_wr) rdata_out <= data_rdata;
    end else if ((state_r == ST_DONE) && (!mem_hold || flush)) begin
      rdata_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_access_ctrl;

  localparam logic [31:0] MASK = 32'h1FFF_FFFF;
  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

  logic        clk, resetn, valid_m, flush, mem_hold, data_addr_ok, data_data_ok;
  logic [5:0]  op_m;
  logic [31:0] addr_m, wdata_m, data_rdata;
  logic        data_req, data_wr, stall_m, rdata_valid, adel, ades;
  logic [1:0]  data_size, addr_low;
  logic [31:0] data_addr, data_wdata, rdata_out;
  logic [3:0]  data_wstrb;
  logic [5:0]  op_out;

  mem_access_ctrl #(.ADDR_MASK(MASK)) dut (
    .clk(clk), .resetn(resetn), .valid_m(valid_m), .op_m(op_m), .addr_m(addr_m),
    .wdata_m(wdata_m), .flush(flush), .mem_hold(mem_hold), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok), .stall_m(stall_m),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .op_out(op_out),
    .addr_low(addr_low), .adel(adel), .ades(ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Access kind: 0 = not a memory op, 1 = load, 2 = store.
  function automatic int kind(input logic [5:0] op);
    case (op)
      LB, LH, LW, LBU, LHU: return 1;
      SB, SH, SW:           return 2;
      default:              return 0;
    endcase
  endfunction

  function automatic int nbytes(input logic [5:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic bit misal(input logic [5:0] op, input logic [31:0] a);
    return (kind(op) != 0) && ((int'(a[1:0]) % nbytes(op)) != 0);
  endfunction

  // Reference model: one outstanding transaction, described by phase flags.
  bit          m_busy = 1'b0, m_acc = 1'b0, m_cancel = 1'b0, m_done = 1'b0;
  bit          m_req = 1'b0, m_wr = 1'b0;
  logic [1:0]  m_size = 2'd0, m_low = 2'd0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic [5:0]  m_op = '0;
  bit          e_idle, e_start, e_adel, e_ades;

  always_comb begin
    e_idle  = !m_busy && !m_done;
    e_start = e_idle && valid_m && (kind(op_m) != 0) && !misal(op_m, addr_m) && !flush && !mem_hold;
    e_adel  = e_idle && valid_m && (kind(op_m) == 1) && misal(op_m, addr_m);
    e_ades  = e_idle && valid_m && (kind(op_m) == 2) && misal(op_m, addr_m);
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0; m_acc <= 1'b0; m_cancel <= 1'b0; m_done <= 1'b0;
      m_req <= 1'b0; m_wr <= 1'b0; m_size <= '0; m_low <= '0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_wstrb <= '0; m_op <= '0;
    end else if (e_start) begin
      m_busy <= 1'b1; m_acc <= 1'b0; m_cancel <= 1'b0; m_req <= 1'b1;
      m_wr   <= (kind(op_m) == 2);
      m_size <= 2'(nbytes(op_m) >> 1);
      m_addr <= addr_m & MASK;
      m_op   <= op_m;
      m_low  <= addr_m[1:0];
      if (kind(op_m) == 2) begin
        m_wstrb <= 4'(((1 << nbytes(op_m)) - 1) << addr_m[1:0]);
        m_wdata <= (nbytes(op_m) == 1) ? 32'(wdata_m[7:0]) * 32'h0101_0101 :
                   (nbytes(op_m) == 2) ? 32'(wdata_m[15:0]) * 32'h0001_0001 : wdata_m;
      end else begin
        m_wstrb <= 4'b0000;
        m_wdata <= 32'h0;
      end
    end else if (m_busy && !m_acc) begin
      if (flush) m_cancel <= 1'b1;
      if (data_addr_ok) begin m_acc <= 1'b1; m_req <= 1'b0; end
    end else if (m_busy) begin
      if (data_data_ok) begin
        m_busy <= 1'b0; m_acc <= 1'b0; m_cancel <= 1'b0;
        if (!m_cancel) begin
          m_done <= 1'b1;
          if (!m_wr) m_rdata <= data_rdata;
        end
      end else if (flush) begin
        m_cancel <= 1'b1;
      end
    end else if (m_done) begin
      if (!mem_hold || flush) m_done <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("data_req",    32'(data_req),    32'(m_req));
      chk("data_wr",     32'(data_wr),     32'(m_wr));
      chk("data_size",   32'(data_size),   32'(m_size));
      chk("data_addr",   data_addr,        m_addr);
      chk("data_wstrb",  32'(data_wstrb),  32'(m_wstrb));
      chk("data_wdata",  data_wdata,       m_wdata);
      chk("stall_m",     32'(stall_m),     32'(e_start || m_busy));
      chk("rdata_out",   rdata_out,        m_rdata);
      chk("rdata_valid", 32'(rdata_valid), 32'(m_done));
      chk("op_out",      32'(op_out),      32'(m_op));
      chk("addr_low",    32'(addr_low),    32'(m_low));
      chk("adel",        32'(adel),        32'(e_adel));
      chk("ades",        32'(ades),        32'(e_ades));
    end
  end

  task automatic idle_inputs();
    valid_m = 1'b0; op_m = 6'd0; addr_m = 32'h0; wdata_m = 32'h0; flush = 1'b0;
    mem_hold = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
  endtask

  // Scripted transaction: start at c=0, addr_ok after aw waits, data_ok after dw waits.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int aw, input int dw, input int flush_at,
                         input int hold_n, output int stalls, output int reqs, output int rvs,
                         output bit stable);
    int done_c;
    logic [31:0] a0, r0;
    bit have_a, have_r;
    done_c = 3 + aw + dw;
    stalls = 0; reqs = 0; rvs = 0; stable = 1'b1; have_a = 1'b0; have_r = 1'b0;
    a0 = '0; r0 = '0;
    for (int c = 0; c <= done_c + hold_n + 1; c++) begin
      valid_m = (c < done_c); op_m = op; addr_m = addr; wdata_m = wd;
      flush        = (c == flush_at);
      mem_hold     = (c >= done_c) && (c < done_c + hold_n);
      data_addr_ok = (c == 1 + aw);
      data_data_ok = (c == 2 + aw + dw);
      data_rdata   = data_data_ok ? rd : 32'h0;
      #1;
      stalls += int'(stall_m); reqs += int'(data_req); rvs += int'(rdata_valid);
      if (data_req) begin
        if (have_a && (data_addr !== a0)) stable = 1'b0;
        a0 = data_addr; have_a = 1'b1;
      end
      if (rdata_valid) begin
        if (have_r && (rdata_out !== r0)) stable = 1'b0;
        r0 = rdata_out; have_r = 1'b1;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  logic [5:0] ops [9] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'b000000};
  int st, rq, rv;
  bit stb;

  initial begin
    idle_inputs();
    resetn = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_req", 32'(data_req), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // LW, one wait cycle on each phase.
    run_txn(LW, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1, 1, -1, 0, st, rq, rv, stb);
    chk("lw_stall_cycles", 32'(st), 32'd5);
    chk("lw_rvalid_cycles", 32'(rv), 32'd1);
    chk("lw_data_addr", data_addr, 32'h0000_0010);
    chk("lw_data_size", 32'(data_size), 32'd2);
    chk("lw_rdata_out", rdata_out, 32'hDEAD_BEEF);
    chk("lw_op_out", 32'(op_out), 32'(6'b100011));
    chk("lw_addr_low", 32'(addr_low), 32'd0);

    // SB to lane 3 and SH to the upper half; minimum latency.
    run_txn(SB, 32'hA000_0003, 32'h0000_00A5, 32'h1111_1111, 0, 0, -1, 0, st, rq, rv, stb);
    chk("sb_stall_cycles", 32'(st), 32'd3);
    chk("sb_data_wr", 32'(data_wr), 32'd1);
    chk("sb_wstrb", 32'(data_wstrb), 32'(4'b1000));
    chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
    chk("sb_data_addr", data_addr, 32'h0000_0003);
    chk("sb_rdata_kept", rdata_out, 32'hDEAD_BEEF);
    chk("model_sb_wstrb", 32'(m_wstrb), 32'(4'b1000));
    chk("model_sb_wdata", m_wdata, 32'hA5A5_A5A5);
    run_txn(SH, 32'hA000_0002, 32'h0000_1234, 32'h0, 0, 0, -1, 0, st, rq, rv, stb);
    chk("sh_wstrb", 32'(data_wstrb), 32'(4'b1100));
    chk("sh_wdata", data_wdata, 32'h1234_1234);
    chk("model_sh_wdata", m_wdata, 32'h1234_1234);

    // Misaligned accesses raise the error flag only.
    valid_m = 1'b1; op_m = LH; addr_m = 32'h8000_0001; #1;
    chk("lh_adel", 32'(adel), 32'd1);
    chk("lh_stall", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    chk("lh_no_req", 32'(data_req), 32'd0);
    op_m = SW; addr_m = 32'h8000_0002; #1;
    chk("sw_ades", 32'(ades), 32'd1);
    chk("sw_adel", 32'(adel), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("sw_no_req", 32'(data_req), 32'd0);

    // Flush during the data phase of an LBU.
    run_txn(LBU, 32'h8000_0021, 32'h0, 32'hCAFE_F00D, 0, 2, 2, 0, st, rq, rv, stb);
    chk("fdata_stall_cycles", 32'(st), 32'd5);
    chk("fdata_req_cycles", 32'(rq), 32'd1);
    chk("fdata_rvalid_cycles", 32'(rv), 32'd0);
    chk("fdata_rdata_kept", rdata_out, 32'hDEAD_BEEF);

    // Flush in the address phase with a slow address acceptance.
    run_txn(LW, 32'h8000_0080, 32'h0, 32'h0BAD_0BAD, 3, 0, 1, 0, st, rq, rv, stb);
    chk("faddr_req_cycles", 32'(rq), 32'd4);
    chk("faddr_addr_stable", 32'(stb), 32'd1);
    chk("faddr_stall_cycles", 32'(st), 32'd6);
    chk("faddr_rvalid_cycles", 32'(rv), 32'd0);

    // Downstream hold keeps the result presented.
    run_txn(LW, 32'h8000_0104, 32'h0, 32'h5A5A_0001, 0, 0, -1, 4, st, rq, rv, stb);
    chk("hold_rvalid_cycles", 32'(rv), 32'd5);
    chk("hold_rdata_stable", 32'(stb), 32'd1);
    chk("hold_rdata_out", rdata_out, 32'h5A5A_0001);

    // Asynchronous reset while in the data phase.
    valid_m = 1'b1; op_m = LW; addr_m = 32'h8000_0040;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; #1;
    chk("prerst_stall", 32'(stall_m), 32'd1);
    valid_m = 1'b0; resetn = 1'b0; #1;
    chk("rst_mid_stall", 32'(stall_m), 32'd0);
    chk("rst_mid_addr", data_addr, 32'd0);
    chk("rst_mid_rdata", rdata_out, 32'd0);
    chk("rst_mid_op_out", 32'(op_out), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run_txn(LW, 32'h8000_0008, 32'h0, 32'h7777_0008, 0, 0, -1, 0, st, rq, rv, stb);
    chk("postrst_stall_cycles", 32'(st), 32'd3);
    chk("postrst_rdata", rdata_out, 32'h7777_0008);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      valid_m      = ($urandom_range(0, 9) < 7);
      op_m         = ops[$urandom_range(0, 8)];
      addr_m       = $urandom;
      wdata_m      = $urandom;
      flush        = ($urandom_range(0, 9) == 0);
      mem_hold     = ($urandom_range(0, 3) == 0);
      data_addr_ok = ($urandom_range(0, 9) < 4);
      data_data_ok = ($urandom_range(0, 9) < 4);
      data_rdata   = $urandom;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory request controller. It sits directly upstream of the load byte-select stage.
- Takes the MEM-stage load/store and checks alignment. It then issues a single SRAM-like transaction (separate address phase and data phase), stalling the pipeline until the transaction completes.
- Provides the raw 32-bit read word, latched opcode and addr[1:0] for byte/halfword extraction.
- For stores it generates the byte strobes and lane-replicated write data. Lane order is little-endian: byte at addr[1:0]=00 is bits 7:0.

Parameters:
- ADDR_MASK, 32'h1FFF_FFFF, AND-mask applied to the virtual address to form data_addr (kseg0/kseg1 fixed translation).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- valid_m  in  1  MEM-stage instruction valid
- op_m  in  6  opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011
- addr_m  in  32  effective virtual address
- wdata_m  in  32  store source (rt)
- flush  in  1  exception/flush of MEM stage
- mem_hold  in  1  downstream stall; the MEM stage cannot advance
- data_req  out  1  request valid
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  physical address
- data_wstrb  out  4  byte strobes
- data_wdata  out  32  write data
- data_addr_ok  in  1  address phase accepted
- data_rdata  in  32  read data
- data_data_ok  in  1  data phase complete
- stall_m  out  1  hold the pipeline
- rdata_out  out  32  raw read word, little-endian lanes
- rdata_valid  out  1  rdata_out/op_out/addr_low are valid for the load byte-select stage
- op_out  out  6  opcode latched at accept
- addr_low  out  2  addr_m[1:0] latched at accept
- adel  out  1  load address error
- ades  out  1  store address error

Behaviour:
- Reset is asynchronous and active-low on resetn.
  - All registers clear: state IDLE, data_req 0, data_wr 0, data_size 0, data_addr 0, data_wstrb 0, data_wdata 0, rdata_out 0, rdata_valid 0, op_out 0, addr_low 0, cancel 0.
- Misalignment is combinational and evaluated only in IDLE with valid_m=1:
  - misaligned = (LH/LHU/SH and addr_m[0]) or (LW/SW and addr_m[1:0]!=0).
  - adel = valid_m & load & misaligned; ades = valid_m & store & misaligned.
  - Both are 0 outside IDLE. A misaligned access issues no request and raises no stall.
- start = IDLE & valid_m & (load|store) & !misaligned & !flush & !mem_hold.
- On start, the following registers load:
  - data_addr = addr_m & ADDR_MASK; data_wr = store; data_size from op; data_req = 1.
  - op_out and addr_low are latched.
- Store strobes and write data:
  - SB: wstrb = 4'b0001 << a[1:0]; wdata = {4{byte}}.
  - SH: wstrb = a[1] ? 4'b1100 : 4'b0011; wdata = {2{half}}.
  - SW: wstrb = 4'b1111; wdata = rt.
  - Loads: wstrb = 0, wdata = 0.
- FSM states are IDLE, ADDR, DATA and DONE.
  - IDLE -> ADDR on start.
  - ADDR: data_req held at 1 with all request fields stable until data_addr_ok. On data_addr_ok, data_req drops to 0 and the FSM goes to DATA.
  - DATA: data_data_ok is sampled only in this state.
    - On data_data_ok with cancel=0: rdata_out <= data_rdata (loads only; stores leave it unchanged), rdata_valid <= 1, go to DONE.
    - On data_data_ok with cancel=1: go to IDLE with rdata_valid 0 and cancel cleared.
  - DONE: rdata_valid=1 and rdata_out/op_out/addr_low are held.
    - Leave to IDLE when mem_hold=0 or flush=1; rdata_valid clears on exit.
    - A new start is not evaluated until the FSM is back in IDLE.
- stall_m = start | ADDR | DATA. It is combinational and is 0 in DONE and for misaligned or flushed accesses.
- The minimum latency is 3 cycles from the start cycle to DONE, assuming data_addr_ok on the first ADDR cycle and data_data_ok on the first DATA cycle.
- Flush mid-operation:
  - In ADDR: data_req is not withdrawn; cancel is set; on data_addr_ok the FSM proceeds to DATA.
  - In DATA: cancel is set.
  - A cancelled transaction never asserts rdata_valid. stall_m stays asserted until the bus transaction drains.
- data_addr_ok together with flush in the same ADDR cycle: both take effect, i.e. go to DATA with cancel=1.
- A store completes identically to a load (DONE pulse), with rdata_valid=1 and rdata_out unchanged. Downstream gates on op_out.
- Reset asserted mid-operation returns to IDLE immediately. The in-flight bus response is not tracked.

Test Plan:
- LW at 0x8000_0010, addr_ok and data_ok each after 1 wait cycle, rdata 0xDEADBEEF -> data_addr 0x0000_0010, data_size 2, stall_m high 5 cycles, DONE with rdata_out 0xDEADBEEF, op_out 100011, addr_low 00.
- SB at 0xA000_0003, rt 0x0000_00A5 -> data_wr 1, data_wstrb 1000, data_wdata 0xA5A5A5A5, data_addr 0x0000_0003. SH at ...0002, rt 0x1234 -> data_wstrb 1100, data_wdata 0x12341234.
- LH at ...0001 -> adel 1, data_req never asserted, stall_m 0. SW at ...0002 -> ades 1.
- Flush during DATA of LBU -> data_req not re-issued, stall_m held until data_ok, then IDLE with rdata_valid never 1.
- Flush asserted while in ADDR, data_addr_ok delayed 3 cycles -> data_req stays 1 with stable addr, then cancel path as above.
- mem_hold=1 for 4 cycles in DONE -> rdata_valid and rdata_out stable for all 4 cycles. resetn pulled low in DATA -> all outputs 0 asynchronously, state IDLE.
